// File: rtl/spi_master_ctrl.sv
// Mode-0 SPI master transaction controller: sequences SCLK/CS_n/MOSI for single bytes
// and bursts, and strobes the spi_rx sampler on every rising SCLK edge.
module spi_master_ctrl #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_tx_valid,
  input  logic [7:0] i_tx_byte,
  input  logic       i_tx_last,
  output logic       o_tx_ready,
  output logic       o_sclk,
  output logic       o_cs_n,
  output logic       o_mosi,
  output logic       o_sample,
  output logic       o_byte_done,
  output logic       o_busy,
  output logic [2:0] o_dbg_state
);

  // Handshake: a byte transfers on a rising clk edge where i_tx_valid & o_tx_ready;
  // the host holds i_tx_byte/i_tx_last stable until then, valid is ignored otherwise.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SETUP     = 3'd1,
    S_HIGH      = 3'd2,
    S_LOW       = 3'd3,
    S_WAIT_NEXT = 3'd4,
    S_HOLD      = 3'd5,
    S_GAP       = 3'd6
  } state_e;

  localparam logic [7:0] DIV_TERM = 8'(CLK_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] div_cnt_q, div_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       last_q, last_d;
  logic       sclk_q, sclk_d;
  logic       cs_n_q, cs_n_d;
  logic       mosi_q, mosi_d;
  logic       sample_q, sample_d;
  logic       byte_done_q, byte_done_d;
  logic       busy_q, busy_d;
  logic       term;
  logic       hs;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      div_cnt_q   <= 8'd0;
      bit_cnt_q   <= 3'd0;
      tx_byte_q   <= 8'd0;
      last_q      <= 1'b0;
      sclk_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      mosi_q      <= 1'b0;
      sample_q    <= 1'b0;
      byte_done_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_byte_q   <= tx_byte_d;
      last_q      <= last_d;
      sclk_q      <= sclk_d;
      cs_n_q      <= cs_n_d;
      mosi_q      <= mosi_d;
      sample_q    <= sample_d;
      byte_done_q <= byte_done_d;
      busy_q      <= busy_d;
    end
  end

  assign o_tx_ready = (state_q == S_IDLE) || (state_q == S_WAIT_NEXT);
  assign hs         = i_tx_valid && o_tx_ready;
  assign term       = (div_cnt_q == DIV_TERM);

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q + 8'd1;
    bit_cnt_d   = bit_cnt_q;
    tx_byte_d   = tx_byte_q;
    last_d      = last_q;
    sclk_d      = sclk_q;
    cs_n_d      = cs_n_q;
    mosi_d      = mosi_q;
    sample_d    = 1'b0;
    // Delayed one cycle so spi_rx has already shifted in bit 0.
    byte_done_d = sample_q && (bit_cnt_q == 3'd7);

    case (state_q)
      S_IDLE, S_WAIT_NEXT: begin
        div_cnt_d = 8'd0;
        if (hs) begin
          tx_byte_d = i_tx_byte;
          last_d    = i_tx_last;
          mosi_d    = i_tx_byte[7];
          cs_n_d    = 1'b0;
          bit_cnt_d = 3'd0;
          state_d   = S_SETUP;
        end
      end
      S_SETUP, S_LOW: begin
        if (term) begin
          div_cnt_d = 8'd0;
          sclk_d    = 1'b1;
          sample_d  = 1'b1;
          state_d   = S_HIGH;
        end
      end
      S_HIGH: begin
        if (term) begin
          div_cnt_d = 8'd0;
          sclk_d    = 1'b0;
          if (bit_cnt_q != 3'd7) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            mosi_d    = tx_byte_q[3'd6 - bit_cnt_q];
            state_d   = S_LOW;
          end else if (last_q) begin
            state_d = S_HOLD;
          end else begin
            state_d = S_WAIT_NEXT;
          end
        end
      end
      S_HOLD: begin
        if (term) begin
          div_cnt_d = 8'd0;
          cs_n_d    = 1'b1;
          mosi_d    = 1'b0;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (term) begin
          div_cnt_d = 8'd0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        div_cnt_d = 8'd0;
        state_d   = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign o_sclk      = sclk_q;
  assign o_cs_n      = cs_n_q;
  assign o_mosi      = mosi_q;
  assign o_sample    = sample_q;
  assign o_byte_done = byte_done_q;
  assign o_busy      = busy_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Scoreboarded bench for spi_master_ctrl at CLK_DIV=4 and CLK_DIV=2; expected event
// times come from the frame timing formulas, received bytes from a loopback shifter.
module tb_spi_master_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic       tx_valid, tx_last, sel, mon_en;
  logic [7:0] tx_byte;
  int         cd;

  logic       rdy4, sclk4, cs4, mosi4, samp4, done4, busy4;
  logic       rdy2, sclk2, cs2, mosi2, samp2, done2, busy2;
  logic [2:0] st4, st2;

  spi_master_ctrl #(.CLK_DIV(4)) dut4 (
    .clk(clk), .reset(reset), .i_tx_valid(tx_valid & ~sel), .i_tx_byte(tx_byte),
    .i_tx_last(tx_last), .o_tx_ready(rdy4), .o_sclk(sclk4), .o_cs_n(cs4),
    .o_mosi(mosi4), .o_sample(samp4), .o_byte_done(done4), .o_busy(busy4),
    .o_dbg_state(st4)
  );

  spi_master_ctrl #(.CLK_DIV(2)) dut2 (
    .clk(clk), .reset(reset), .i_tx_valid(tx_valid & sel), .i_tx_byte(tx_byte),
    .i_tx_last(tx_last), .o_tx_ready(rdy2), .o_sclk(sclk2), .o_cs_n(cs2),
    .o_mosi(mosi2), .o_sample(samp2), .o_byte_done(done2), .o_busy(busy2),
    .o_dbg_state(st2)
  );

  logic       m_ready, m_sclk, m_cs, m_mosi, m_sample, m_done, m_busy;
  logic [2:0] m_state;
  assign m_ready  = sel ? rdy2  : rdy4;
  assign m_sclk   = sel ? sclk2 : sclk4;
  assign m_cs     = sel ? cs2   : cs4;
  assign m_mosi   = sel ? mosi2 : mosi4;
  assign m_sample = sel ? samp2 : samp4;
  assign m_done   = sel ? done2 : done4;
  assign m_busy   = sel ? busy2 : busy4;
  assign m_state  = sel ? st2   : st4;

  // ---------------- scoreboard ----------------
  logic [32:0] samp_q[$];   // {cycle, expected mosi}
  logic [39:0] done_q[$];   // {cycle, expected byte}
  logic [31:0] cs_q[$];     // cycle of cs_n rising
  logic [31:0] rdy_q[$];    // cycle of o_tx_ready rising

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: the whole frame follows from the handshake cycle t.
  task automatic predict(input int unsigned t, input logic [7:0] b, input logic last);
    for (int k = 0; k < 8; k++)
      samp_q.push_back({32'(t + 1 + (2 * k + 1) * cd), b[7 - k]});
    done_q.push_back({32'(t + 2 + 15 * cd), b});
    if (last) begin
      cs_q.push_back(32'(t + 1 + 17 * cd));
      rdy_q.push_back(32'(t + 1 + 18 * cd));
    end else begin
      rdy_q.push_back(32'(t + 1 + 16 * cd));
    end
  endtask

  // ---------------- monitor ----------------
  logic       p_sclk, p_cs, p_rdy, p_mosi;
  logic [7:0] rx_sh = 8'd0;
  logic [32:0] es;
  logic [39:0] ed;
  logic [31:0] et;

  always @(negedge clk) begin
    if (!mon_en) begin
      p_sclk = 1'b0; p_cs = 1'b1; p_rdy = 1'b1; p_mosi = 1'b0;
    end else begin
      if (m_sample) begin
        rx_sh = {rx_sh[6:0], m_mosi};
        check("sample_expected", samp_q.size() != 0, 1);
        if (samp_q.size() != 0) begin
          es = samp_q.pop_front();
          check("sample_cycle", cyc, es[32:1]);
          check("sample_mosi", m_mosi, es[0]);
          check("sample_cs_low", m_cs, 0);
        end
      end
      if (m_sclk && !p_sclk) check("sclk_rise_with_sample", m_sample, 1);
      if (m_sclk && p_sclk) check("mosi_stable_while_high", m_mosi, p_mosi);
      if (m_done) begin
        check("done_expected", done_q.size() != 0, 1);
        if (done_q.size() != 0) begin
          ed = done_q.pop_front();
          check("done_cycle", cyc, ed[39:8]);
          check("rx_byte", rx_sh, ed[7:0]);
        end
      end
      if (m_cs && !p_cs) begin
        check("cs_rise_expected", cs_q.size() != 0, 1);
        if (cs_q.size() != 0) begin
          et = cs_q.pop_front();
          check("cs_rise_cycle", cyc, et);
        end
      end
      if (m_ready && !p_rdy) begin
        check("ready_rise_expected", rdy_q.size() != 0, 1);
        if (rdy_q.size() != 0) begin
          et = rdy_q.pop_front();
          check("ready_rise_cycle", cyc, et);
        end
      end
      p_sclk = m_sclk; p_cs = m_cs; p_rdy = m_ready; p_mosi = m_mosi;
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the handshake edge, valid left high.
  task automatic send(input logic [7:0] b, input logic last, output int unsigned t);
    int waited = 0;
    tx_valid = 1'b1;
    tx_byte  = b;
    tx_last  = last;
    t = 0;
    forever begin
      @(negedge clk);
      if (m_ready) break;
      waited++;
      if (waited > 3000) begin
        check("handshake_timeout", waited, 0);
        return;
      end
    end
    t = cyc;
    predict(t, b, last);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    tx_valid = 1'b0;
    while ((samp_q.size() + done_q.size() + cs_q.size() + rdy_q.size() != 0 || m_busy)
           && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("drained", samp_q.size() + done_q.size() + cs_q.size() + rdy_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int unsigned target);
    while (cyc < target) begin
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  int unsigned t, t2;
  logic [7:0]  rb;
  logic        rl;

  initial begin
    reset = 1'b1; tx_valid = 1'b0; tx_byte = 8'h00; tx_last = 1'b0;
    sel = 1'b0; cd = 4; mon_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", cs4, 1);
    check("rst_sclk", sclk4, 0);
    check("rst_mosi", mosi4, 0);
    check("rst_sample", samp4, 0);
    check("rst_done", done4, 0);
    check("rst_busy", busy4, 0);
    check("rst_ready", rdy4, 1);
    check("rst_state", st4, 0);
    check("rst_cs_n_div2", cs2, 1);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1; mon_en = 1'b1;

    // single byte
    send(8'hA5, 1'b1, t);
    drain();

    // loopback bytes
    send(8'h3C, 1'b1, t); drain();
    send(8'hFF, 1'b1, t); drain();
    send(8'h00, 1'b1, t); drain();

    // burst, second byte offered 10 cycles into WAIT_NEXT
    send(8'h12, 1'b0, t);
    tx_valid = 1'b0;
    wait_until(t + 1 + 16 * cd + 10);
    check("gap_sclk_low", m_sclk, 0);
    check("gap_cs_low", m_cs, 0);
    check("gap_ready", m_ready, 1);
    send(8'h34, 1'b1, t2);
    check("burst_handshake_cycle", t2, t + 1 + 16 * cd + 10);
    drain();

    // valid held high with a different byte while busy
    send(8'h5A, 1'b1, t);
    send(8'hC3, 1'b1, t2);
    check("held_valid_next_handshake", t2, t + 1 + 18 * cd);
    drain();

    // reset at the 5th sample strobe
    send(8'hE7, 1'b1, t);
    tx_valid = 1'b0;
    do @(negedge clk); while (cyc < t + 1 + 9 * cd);
    #2;
    check("pre_reset_sample", m_sample, 1);
    reset = 1'b1;
    mon_en = 1'b0;
    samp_q.delete(); done_q.delete(); cs_q.delete(); rdy_q.delete();
    #1;
    check("midrst_cs_n", m_cs, 1);
    check("midrst_sclk", m_sclk, 0);
    check("midrst_done", m_done, 0);
    check("midrst_sample", m_sample, 0);
    check("midrst_busy", m_busy, 0);
    check("midrst_ready", m_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    check("midrst_done_held", m_done, 0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1; mon_en = 1'b1;
    send(8'h81, 1'b1, t);
    drain();

    // randomized bursts
    for (int i = 0; i < 12; i++) begin
      rb = 8'($urandom_range(0, 255));
      rl = (i == 11) || ($urandom_range(0, 3) == 0);
      send(rb, rl, t);
      tx_valid = 1'b0;
      repeat ($urandom_range(0, 20)) @(posedge clk);
      #1;
    end
    drain();

    // CLK_DIV=2 instance
    mon_en = 1'b0;
    sel = 1'b1;
    cd = 2;
    @(posedge clk); #1;
    mon_en = 1'b1;
    send(8'h96, 1'b1, t);
    drain();
    send(8'h69, 1'b0, t);
    send(8'hF0, 1'b1, t2);
    check("div2_burst_back_to_back", t2, t + 1 + 16 * cd);
    drain();
    for (int i = 0; i < 4; i++) begin
      rb = 8'($urandom_range(0, 255));
      send(rb, i == 3, t);
      tx_valid = 1'b0;
      repeat ($urandom_range(0, 6)) @(posedge clk);
      #1;
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
